// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: default depth, load latency,
// the "read register file" forwarding code and the saturating counter helper.
package hazard_scoreboard_pkg;
  localparam int          REG_ADDR_W_DEF = 5;
  localparam int          STAGES_DEF     = 3;
  localparam int          LOAD_LAT_DEF   = 1;
  localparam int          FWD_SEL_REG    = 0;
  localparam logic [31:0] CNT_MAX        = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// hazard_src_match: compares one ID source operand against every in-flight
// entry and reports the youngest (lowest index) producer plus whether that
// producer is a load whose data is not yet available.
module hazard_src_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int STAGES     = STAGES_DEF,
  parameter int LOAD_LAT   = LOAD_LAT_DEF,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic [REG_ADDR_W-1:0]             src,
  input  logic                              src_used,
  input  logic                              id_valid,
  input  logic [STAGES-1:0]                 ent_vld,
  input  logic [STAGES-1:0]                 ent_we,
  input  logic [STAGES-1:0]                 ent_ld,
  input  logic [STAGES-1:0][REG_ADDR_W-1:0] ent_dst,
  output logic                              hit,
  output logic [SEL_W-1:0]                  idx,
  output logic                              ld_blk
);

  // Scan oldest to youngest so the youngest match overwrites; r0 never matches.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    ld_blk = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (src_used && id_valid && ent_vld[k] && ent_we[k] &&
          (ent_dst[k] == src) && (src != '0)) begin
        hit    = 1'b1;
        idx    = SEL_W'(k);
        ld_blk = ent_ld[k] && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes from EX to WB, raises
// stall for load-use (or any non-WB hazard without forwarding) and drives
// per-operand forwarding selects. Optional feature macro: FORWARD_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int STAGES     = STAGES_DEF,
  parameter int LOAD_LAT   = LOAD_LAT_DEF,
  localparam int SEL_W     = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_dst_we,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_rs_sel,
  output logic [SEL_W-1:0]      fwd_rt_sel,
  output logic [31:0]           stall_count
);

  localparam int NSRC = 2;  // operand 0 = rs, operand 1 = rt

  logic [STAGES-1:0]                 vld_pipe, ent_we, ent_ld;
  logic [STAGES-1:0][REG_ADDR_W-1:0] ent_dst;

  logic [NSRC-1:0][REG_ADDR_W-1:0] src;
  logic [NSRC-1:0]                 src_used, hit, blk;
  logic [NSRC-1:0][SEL_W-1:0]      idx;

  assign src      = {id_rt, id_rs};
  assign src_used = {id_rt_used, id_rs_used};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    hazard_src_match #(
      .REG_ADDR_W(REG_ADDR_W), .STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
    ) u_match (
      .src      (src[s]),
      .src_used (src_used[s]),
      .id_valid (id_valid),
      .ent_vld  (vld_pipe),
      .ent_we   (ent_we),
      .ent_ld   (ent_ld),
      .ent_dst  (ent_dst),
      .hit      (hit[s]),
      .idx      (idx[s]),
      .ld_blk   (blk[s])
    );
  end

`ifdef FORWARD_EN
  // Forward from the youngest producer; only a not-yet-ready load stalls.
  always_comb begin
    stall      = !flush && |(hit & blk);
    fwd_rs_sel = SEL_W'(FWD_SEL_REG);
    fwd_rt_sel = SEL_W'(FWD_SEL_REG);
    if (!flush && !stall) begin
      if (hit[0]) fwd_rs_sel = idx[0] + SEL_W'(1);
      if (hit[1]) fwd_rt_sel = idx[1] + SEL_W'(1);
    end
  end
`else
  logic [NSRC-1:0] unused_blk;
  assign unused_blk = blk;

  // No bypass network: any producer short of WB stalls (WB is write-through).
  always_comb begin
    stall      = 1'b0;
    fwd_rs_sel = SEL_W'(FWD_SEL_REG);
    fwd_rt_sel = SEL_W'(FWD_SEL_REG);
    for (int s = 0; s < NSRC; s++)
      if (hit[s] && (idx[s] != SEL_W'(STAGES - 1))) stall = 1'b1;
    if (flush) stall = 1'b0;
  end
`endif

  // Entry shift register: ID enters at 0 unless stalled/flushed (then a bubble).
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe    <= '0;
      ent_we      <= '0;
      ent_ld      <= '0;
      ent_dst     <= '0;
      stall_count <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], id_valid && !stall && !flush};
      ent_we   <= {ent_we[STAGES-2:0], id_dst_we};
      ent_ld   <= {ent_ld[STAGES-2:0], id_is_load};
      ent_dst  <= {ent_dst[STAGES-2:0], id_dst};
      if (stall) stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard (STAGES=3, LOAD_LAT=1),
// expectations follow the FORWARD_EN setting of the build.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_dst_we, id_is_load, flush;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
    .id_dst_we(id_dst_we), .id_is_load(id_is_load), .flush(flush),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_count(stall_count)
  );

  typedef struct {
    logic       vld, rsu, rtu, we, ld, fl;
    logic [4:0] rs, rt, dst;
    logic       st;
    logic [1:0] srs, srt;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int vld, rs, rt, rsu, rtu, dst, we, ld, fl,
                              st, srs, srt, cnt);
    vec_t v;
    v.vld = vld[0]; v.rs = rs[4:0]; v.rt = rt[4:0]; v.rsu = rsu[0]; v.rtu = rtu[0];
    v.dst = dst[4:0]; v.we = we[0]; v.ld = ld[0]; v.fl = fl[0];
    v.st = st[0]; v.srs = srs[1:0]; v.srt = srt[1:0]; v.cnt = 32'(cnt);
    return v;
  endfunction

  task automatic nops(input int n, input int cnt);
    for (int i = 0; i < n; i++) tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,cnt));
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.vld; id_rs = v.rs; id_rt = v.rt; id_rs_used = v.rsu;
    id_rt_used = v.rtu; id_dst = v.dst; id_dst_we = v.we; id_is_load = v.ld;
    flush = v.fl;
  endtask

  task automatic apply(input vec_t v, input int row);
    drive(v);
    #1;
    chk("stall", row, 32'(stall), 32'(v.st));
    chk("fwd_rs_sel", row, 32'(fwd_rs_sel), 32'(v.srs));
    chk("fwd_rt_sel", row, 32'(fwd_rt_sel), 32'(v.srt));
    chk("stall_count", row, stall_count, v.cnt);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int c;
    rst = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0));
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset_stall", -1, 32'(stall), 32'd0);
    chk("reset_rs_sel", -1, 32'(fwd_rs_sel), 32'd0);
    chk("reset_rt_sel", -1, 32'(fwd_rt_sel), 32'd0);
    chk("reset_count", -1, stall_count, 32'd0);
    rst = 1'b1;

`ifdef FORWARD_EN
    tbl.push_back(mk(1,1,2,1,1,3,1,0,0, 0,0,0,0));  // add r3
    tbl.push_back(mk(1,3,1,1,1,4,1,0,0, 0,1,0,0));  // sub r4,r3,r1 -> EX forward
    nops(3, 0);
    tbl.push_back(mk(1,1,0,1,0,5,1,1,0, 0,0,0,0));  // lw r5
    tbl.push_back(mk(1,5,5,1,1,6,1,0,0, 1,0,0,0));  // add r6,r5,r5 load-use stall
    tbl.push_back(mk(1,5,5,1,1,6,1,0,0, 0,2,2,1));  // then forward from MEM
    tbl.push_back(mk(1,0,0,1,0,0,1,0,0, 0,0,0,1));  // addi r0,r0,7
    tbl.push_back(mk(1,0,0,1,1,1,1,0,0, 0,0,0,1));  // add r1,r0,r0
    nops(3, 1);
    tbl.push_back(mk(1,1,0,1,0,5,1,1,0, 0,0,0,1));  // lw r5
    tbl.push_back(mk(1,5,6,1,1,0,0,0,1, 0,0,0,1));  // beq r5 with flush
    tbl.push_back(mk(1,5,1,1,1,7,1,0,0, 0,2,0,1));  // reader of r5, lw now at entry 1
    nops(3, 1);
    tbl.push_back(mk(1,1,1,1,1,2,1,0,0, 0,0,0,1));  // add r2
    tbl.push_back(mk(1,1,1,1,1,2,1,0,0, 0,0,0,1));  // add r2
    tbl.push_back(mk(1,2,2,1,1,7,1,0,0, 0,1,1,1));  // or r7,r2,r2 youngest
    nops(1, 1);
    tbl.push_back(mk(1,2,7,1,1,8,1,0,0, 0,3,2,1));  // r2 from WB, r7 from MEM
    tbl.push_back(mk(1,8,8,0,0,0,0,0,0, 0,0,0,1));  // sources not used
    tbl.push_back(mk(0,8,8,1,1,0,0,0,0, 0,0,0,1));  // ID not valid
    nops(3, 1);
    c = 1;
`else
    tbl.push_back(mk(1,1,2,1,1,3,1,0,0, 0,0,0,0));  // add r3
    tbl.push_back(mk(1,3,1,1,1,4,1,0,0, 1,0,0,0));  // sub r4,r3,r1 stalls
    tbl.push_back(mk(1,3,1,1,1,4,1,0,0, 1,0,0,1));
    tbl.push_back(mk(1,3,1,1,1,4,1,0,0, 0,0,0,2));  // producer in WB
    nops(3, 2);
    tbl.push_back(mk(1,1,0,1,0,5,1,1,0, 0,0,0,2));  // lw r5
    tbl.push_back(mk(1,5,5,1,1,6,1,0,0, 1,0,0,2));
    tbl.push_back(mk(1,5,5,1,1,6,1,0,0, 1,0,0,3));
    tbl.push_back(mk(1,5,5,1,1,6,1,0,0, 0,0,0,4));
    tbl.push_back(mk(1,0,0,1,0,0,1,0,0, 0,0,0,4));  // addi r0,r0,7
    tbl.push_back(mk(1,0,0,1,1,1,1,0,0, 0,0,0,4));  // add r1,r0,r0
    nops(3, 4);
    tbl.push_back(mk(1,1,0,1,0,5,1,1,0, 0,0,0,4));  // lw r5
    tbl.push_back(mk(1,5,6,1,1,0,0,0,1, 0,0,0,4));  // beq r5 with flush
    tbl.push_back(mk(1,5,1,1,1,7,1,0,0, 1,0,0,4));  // lw at entry 1 still stalls
    tbl.push_back(mk(1,5,1,1,1,7,1,0,0, 0,0,0,5));
    nops(3, 5);
    tbl.push_back(mk(1,1,1,1,1,2,1,0,0, 0,0,0,5));  // add r2
    tbl.push_back(mk(1,1,1,1,1,2,1,0,0, 0,0,0,5));  // add r2
    tbl.push_back(mk(1,2,2,1,1,7,1,0,0, 1,0,0,5));  // or r7,r2,r2
    tbl.push_back(mk(1,2,2,1,1,7,1,0,0, 1,0,0,6));
    tbl.push_back(mk(1,2,2,1,1,7,1,0,0, 0,0,0,7));
    tbl.push_back(mk(1,7,7,0,0,0,0,0,0, 0,0,0,7));  // sources not used
    tbl.push_back(mk(0,7,7,1,1,0,0,0,0, 0,0,0,7));  // ID not valid
    nops(3, 7);
    c = 7;
`endif

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset in the middle of a load-use stall.
    apply(mk(1,1,0,1,0,5,1,1,0, 0,0,0,c), 1000);
    drive(mk(1,5,5,1,1,6,1,0,0, 0,0,0,0));
    #1;
    chk("pre_reset_stall", 1001, 32'(stall), 32'd1);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_reset_stall", 1002, 32'(stall), 32'd0);
    chk("post_reset_rs_sel", 1002, 32'(fwd_rs_sel), 32'd0);
    chk("post_reset_rt_sel", 1002, 32'(fwd_rt_sel), 32'd0);
    chk("post_reset_count", 1002, stall_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
